// File: rtl/mem_access_unit_pkg.sv
// mem_access_pkg: shared types and sizing for the 3-lane strided memory access unit.
package mem_access_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int MEM_WORDS = 1000;
   localparam int NLANES = 3;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   typedef logic [NLANES-1:0][DATA_W-1:0] lane_data_t;
   typedef logic [NLANES-1:0][ADDR_W-1:0] lane_addr_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_req_if / mem_port_if: pipeline request/response bus and 3-port data memory bus.
interface mem_req_if;
   import mem_access_pkg::*;
   logic reqValid, reqReady, reqWrite;
   logic [ADDR_W-1:0] reqBase, reqStride;
   logic [NLANES-1:0] reqMask;
   logic [DATA_W-1:0] reqWD1, reqWD2, reqWD3;
   logic respValid, respReady, respError;
   logic [DATA_W-1:0] respRD1, respRD2, respRD3;
   modport master(output reqValid, reqWrite, reqBase, reqStride, reqMask, reqWD1, reqWD2, reqWD3, respReady,
                  input reqReady, respValid, respError, respRD1, respRD2, respRD3);
   modport slave(input reqValid, reqWrite, reqBase, reqStride, reqMask, reqWD1, reqWD2, reqWD3, respReady,
                 output reqReady, respValid, respError, respRD1, respRD2, respRD3);
endinterface

interface mem_port_if;
   import mem_access_pkg::*;
   logic [ADDR_W-1:0] memPos1, memPos2, memPos3;
   logic [DATA_W-1:0] memWD1, memWD2, memWD3;
   logic memOE, memWEnable;
   logic [DATA_W-1:0] memRD1, memRD2, memRD3;
   modport master(output memPos1, memPos2, memPos3, memWD1, memWD2, memWD3, memOE, memWEnable,
                  input memRD1, memRD2, memRD3);
   modport slave(input memPos1, memPos2, memPos3, memWD1, memWD2, memWD3, memOE, memWEnable,
                 output memRD1, memRD2, memRD3);
endinterface

// File: rtl/mem_access_unit_lane_addr_gen.sv
// lane_addr_gen: strided lane addresses, per-lane checks, masked-lane fill and store collision resolution.
module lane_addr_gen
   import mem_access_pkg::*;
(
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] stride,
   input  logic [NLANES-1:0] mask,
   input  lane_data_t        wd,
   output logic [NLANES-1:0] aligned,
   output logic [NLANES-1:0] in_range,
   output lane_addr_t        pos,
   output lane_data_t        data
);
   lane_addr_t addr;
   lane_data_t res;
   logic [1:0] lo;
   always_comb begin
      addr[0] = base;
      for (int i = 1; i < NLANES; i++) addr[i] = addr[i-1] + stride;
      for (int i = 0; i < NLANES; i++) begin
         aligned[i] = addr[i][1:0] == 2'b00;
         in_range[i] = 32'(addr[i][ADDR_W-1:2]) < MEM_WORDS;
      end
      lo = '0;
      for (int i = NLANES-1; i >= 0; i--) if (mask[i]) lo = 2'(i);
      // the last matching higher lane wins, so colliding ports all carry the top lane's data
      res = wd;
      for (int i = 0; i < NLANES; i++)
         for (int j = i + 1; j < NLANES; j++)
            if (mask[i] && mask[j] && addr[i][ADDR_W-1:2] == addr[j][ADDR_W-1:2]) res[i] = wd[j];
      for (int i = 0; i < NLANES; i++) begin
         pos[i] = mask[i] ? addr[i] : addr[lo];
         data[i] = mask[i] ? res[i] : res[lo];
      end
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: accepts one 3-lane strided load/store, drives the 3-port data memory, returns a registered response.
module mem_access_unit
   import mem_access_pkg::*;
(
   input logic       clock,
   input logic       nReset,
   mem_req_if.slave  req,
   mem_port_if.master mem
);
   state_t state, next;
   lane_addr_t pos, mem_pos;
   lane_data_t data, mem_wd, rd, mem_rd;
   logic [NLANES-1:0] aligned, in_range, mask_q;
   logic err, empty, err_q, oe, we;
   lane_addr_gen u_gen (
      .base(req.reqBase),
      .stride(req.reqStride),
      .mask(req.reqMask),
      .wd({req.reqWD3, req.reqWD2, req.reqWD1}),
      .aligned,
      .in_range,
      .pos,
      .data
   );
   assign err = |(req.reqMask & ~(aligned & in_range));
   assign empty = req.reqMask == '0;
   always_ff @(posedge clock) begin
      if (!nReset) state <= IDLE;
      else state <= next;
   end
   always_comb begin
      next = state == IDLE  ? (req.reqValid ? ((err || empty) ? RESP : ISSUE) : IDLE) :
             state == ISSUE ? RESP :
             (req.respReady ? IDLE : RESP);
   end
   always_comb begin
      req.reqReady = state == IDLE;
      req.respValid = state == RESP;
   end
   // rejected and empty requests leave the memory-side registers untouched
   always_ff @(posedge clock) begin
      if (!nReset) begin
         mem_pos <= '0;
         mem_wd <= '0;
         oe <= 1'b0;
         we <= 1'b0;
         rd <= '0;
         err_q <= 1'b0;
         mask_q <= '0;
      end else if (state == IDLE && req.reqValid) begin
         err_q <= err;
         rd <= '0;
         if (!err && !empty) begin
            mem_pos <= pos;
            mem_wd <= data;
            oe <= !req.reqWrite;
            we <= req.reqWrite;
            mask_q <= req.reqMask;
         end
      end else if (state == ISSUE) begin
         oe <= 1'b0;
         we <= 1'b0;
         if (oe) for (int i = 0; i < NLANES; i++) rd[i] <= mask_q[i] ? mem_rd[i] : '0;
      end
   end
   assign mem_rd = {mem.memRD3, mem.memRD2, mem.memRD1};
   assign mem.memPos1 = mem_pos[0];
   assign mem.memPos2 = mem_pos[1];
   assign mem.memPos3 = mem_pos[2];
   assign mem.memWD1 = mem_wd[0];
   assign mem.memWD2 = mem_wd[1];
   assign mem.memWD3 = mem_wd[2];
   assign mem.memOE = oe;
   assign mem.memWEnable = we;
   assign req.respError = err_q;
   assign req.respRD1 = rd[0];
   assign req.respRD2 = rd[1];
   assign req.respRD3 = rd[2];
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a 1000-word 3-port memory model.
module tb_mem_access_unit;
   logic clock = 1'b0;
   logic nReset;
   int n_checks = 0;
   int n_fail = 0;
   int we_cnt = 0;
   int oe_cnt = 0;
   int w0, o0, lat;
   logic [15:0] ram [0:16383];
   bit written [0:16383];

   mem_req_if q();
   mem_port_if m();

   mem_access_unit dut (.clock(clock), .nReset(nReset), .req(q), .mem(m));

   always #5 clock = ~clock;

   // untouched words read back as 0xD000 | word index
   function automatic logic [15:0] peek(input logic [15:0] p);
      return written[p[15:2]] ? ram[p[15:2]] : (16'hD000 | 16'(p[15:2]));
   endfunction

   assign m.memRD1 = m.memOE ? peek(m.memPos1) : 16'h0;
   assign m.memRD2 = m.memOE ? peek(m.memPos2) : 16'h0;
   assign m.memRD3 = m.memOE ? peek(m.memPos3) : 16'h0;

   always @(posedge clock) begin
      if (m.memWEnable) begin
         we_cnt <= we_cnt + 1;
         ram[m.memPos1[15:2]] <= m.memWD1;
         ram[m.memPos2[15:2]] <= m.memWD2;
         ram[m.memPos3[15:2]] <= m.memWD3;
         written[m.memPos1[15:2]] <= 1'b1;
         written[m.memPos2[15:2]] <= 1'b1;
         written[m.memPos3[15:2]] <= 1'b1;
      end
      if (m.memOE) oe_cnt <= oe_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic w, input logic [15:0] b, input logic [15:0] s, input logic [2:0] k,
                       input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
      q.reqWrite = w;
      q.reqBase = b;
      q.reqStride = s;
      q.reqMask = k;
      q.reqWD1 = d1;
      q.reqWD2 = d2;
      q.reqWD3 = d3;
      q.reqValid = 1'b1;
      tick;
      q.reqValid = 1'b0;
   endtask

   task automatic wait_resp(output int l);
      l = 1;
      while (!q.respValid && l < 20) begin
         tick;
         l++;
      end
   endtask

   task automatic finish(input string tag, input int el, input logic ee,
                         input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
      int l;
      wait_resp(l);
      check({tag, ".lat"}, l, el);
      check({tag, ".err"}, q.respError, ee);
      check({tag, ".rd1"}, q.respRD1, e1);
      check({tag, ".rd2"}, q.respRD2, e2);
      check({tag, ".rd3"}, q.respRD3, e3);
      q.respReady = 1'b1;
      tick;
      q.respReady = 1'b0;
   endtask

   task automatic xfer(input string tag, input logic w, input logic [15:0] b, input logic [15:0] s,
                       input logic [2:0] k, input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3,
                       input int el, input logic ee, input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
      send(w, b, s, k, d1, d2, d3);
      finish(tag, el, ee, e1, e2, e3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      nReset = 1'b0;
      q.reqValid = 1'b0;
      q.reqWrite = 1'b0;
      q.reqBase = '0;
      q.reqStride = '0;
      q.reqMask = '0;
      q.reqWD1 = '0;
      q.reqWD2 = '0;
      q.reqWD3 = '0;
      q.respReady = 1'b0;
      tick;
      tick;
      check("rst.reqReady", q.reqReady, 1'b1);
      check("rst.respValid", q.respValid, 1'b0);
      check("rst.respError", q.respError, 1'b0);
      check("rst.memOE", m.memOE, 1'b0);
      check("rst.memWEnable", m.memWEnable, 1'b0);
      check("rst.memPos1", m.memPos1, 16'h0);
      check("rst.respRD1", q.respRD1, 16'h0);
      nReset = 1'b1;
      tick;
      w0 = we_cnt;
      send(1'b1, 16'h0010, 16'd4, 3'b111, 16'hAAAA, 16'hBBBB, 16'hCCCC);
      check("st1.we", m.memWEnable, 1'b1);
      check("st1.oe", m.memOE, 1'b0);
      check("st1.pos1", m.memPos1, 16'h0010);
      check("st1.pos2", m.memPos2, 16'h0014);
      check("st1.pos3", m.memPos3, 16'h0018);
      check("st1.rv_early", q.respValid, 1'b0);
      finish("st1", 2, 1'b0, 16'h0, 16'h0, 16'h0);
      check("st1.we_pulses", we_cnt - w0, 1);
      o0 = oe_cnt;
      xfer("ld1", 1'b0, 16'h0010, 16'd4, 3'b111, 16'h0, 16'h0, 16'h0, 2, 1'b0, 16'hAAAA, 16'hBBBB, 16'hCCCC);
      check("ld1.oe_pulses", oe_cnt - o0, 1);
      send(1'b1, 16'h0020, 16'd4, 3'b010, 16'hFFFF, 16'h1234, 16'hFFFF);
      check("st2.pos1", m.memPos1, 16'h0024);
      check("st2.pos2", m.memPos2, 16'h0024);
      check("st2.pos3", m.memPos3, 16'h0024);
      check("st2.wd1", m.memWD1, 16'h1234);
      check("st2.wd2", m.memWD2, 16'h1234);
      check("st2.wd3", m.memWD3, 16'h1234);
      finish("st2", 2, 1'b0, 16'h0, 16'h0, 16'h0);
      xfer("ld2", 1'b0, 16'h0020, 16'd4, 3'b111, 16'h0, 16'h0, 16'h0, 2, 1'b0, 16'hD008, 16'h1234, 16'hD00A);
      send(1'b1, 16'h0040, 16'd0, 3'b111, 16'h0001, 16'h0002, 16'h0003);
      check("st3.wd1", m.memWD1, 16'h0003);
      check("st3.wd2", m.memWD2, 16'h0003);
      check("st3.wd3", m.memWD3, 16'h0003);
      finish("st3", 2, 1'b0, 16'h0, 16'h0, 16'h0);
      xfer("ld3", 1'b0, 16'h0040, 16'd0, 3'b111, 16'h0, 16'h0, 16'h0, 2, 1'b0, 16'h0003, 16'h0003, 16'h0003);
      o0 = oe_cnt;
      xfer("mis", 1'b0, 16'h0002, 16'd4, 3'b111, 16'h0, 16'h0, 16'h0, 1, 1'b1, 16'h0, 16'h0, 16'h0);
      xfer("oor", 1'b0, 16'h0F98, 16'd4, 3'b111, 16'h0, 16'h0, 16'h0, 1, 1'b1, 16'h0, 16'h0, 16'h0);
      check("rej.oe_pulses", oe_cnt - o0, 0);
      xfer("oor_m", 1'b0, 16'h0F98, 16'd4, 3'b011, 16'h0, 16'h0, 16'h0, 2, 1'b0, 16'hD3E6, 16'hD3E7, 16'h0);
      xfer("mis_m", 1'b0, 16'h0010, 16'd2, 3'b001, 16'h0, 16'h0, 16'h0, 2, 1'b0, 16'hAAAA, 16'h0, 16'h0);
      w0 = we_cnt;
      xfer("empty", 1'b1, 16'h0010, 16'd4, 3'b000, 16'h1111, 16'h2222, 16'h3333, 1, 1'b0, 16'h0, 16'h0, 16'h0);
      check("empty.we_pulses", we_cnt - w0, 0);
      send(1'b0, 16'h0010, 16'd4, 3'b111, 16'h0, 16'h0, 16'h0);
      wait_resp(lat);
      check("stall.lat", lat, 2);
      w0 = we_cnt;
      q.reqWrite = 1'b1;
      q.reqBase = 16'h0100;
      q.reqMask = 3'b111;
      q.reqWD1 = 16'h7777;
      q.reqValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall.respValid", q.respValid, 1'b1);
         check("stall.reqReady", q.reqReady, 1'b0);
         check("stall.rd1", q.respRD1, 16'hAAAA);
         check("stall.rd3", q.respRD3, 16'hCCCC);
         tick;
      end
      q.respReady = 1'b1;
      tick;
      q.respReady = 1'b0;
      check("hs.respValid", q.respValid, 1'b0);
      check("hs.reqReady", q.reqReady, 1'b1);
      q.reqValid = 1'b0;
      tick;
      check("hs.memWEnable", m.memWEnable, 1'b0);
      check("hs.we_pulses", we_cnt - w0, 0);
      send(1'b0, 16'h0010, 16'd4, 3'b111, 16'h0, 16'h0, 16'h0);
      wait_resp(lat);
      check("rstresp.lat", lat, 2);
      nReset = 1'b0;
      tick;
      nReset = 1'b1;
      check("rstresp.respValid", q.respValid, 1'b0);
      check("rstresp.reqReady", q.reqReady, 1'b1);
      check("rstresp.memOE", m.memOE, 1'b0);
      check("rstresp.rd1", q.respRD1, 16'h0);
      send(1'b1, 16'h0080, 16'd4, 3'b001, 16'h5A5A, 16'h0, 16'h0);
      check("rstwr.we", m.memWEnable, 1'b1);
      nReset = 1'b0;
      tick;
      nReset = 1'b1;
      check("rstwr.respValid", q.respValid, 1'b0);
      check("rstwr.memWEnable", m.memWEnable, 1'b0);
      xfer("ld_rst", 1'b0, 16'h0080, 16'd4, 3'b001, 16'h0, 16'h0, 16'h0, 2, 1'b0, 16'h5A5A, 16'h0, 16'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
